// File: rtl/mmu_walk_pkg.sv
// mmu_walk_pkg: shared types and constants for the PMMU table-walk sequencer
package mmu_walk_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DECODE, DONE, FAULT} walk_state_t;
  localparam logic [1:0] DT_INVALID = 2'd0;
  localparam logic [1:0] DT_PAGE = 2'd1;
  localparam logic [31:0] TBL_ADDR_MASK = 32'hFFFF_FFF0;
  localparam int PG_ATTR_W_DEF = 8;
  // TI field for a level, TIA (level 0) sits in the top nibble
  function automatic logic [3:0] ti_field(input logic [15:0] ti, input logic [1:0] lvl);
    return 4'(ti >> (4'd12 - {lvl, 2'b00}));
  endfunction
endpackage

// File: rtl/mmu_walk_index_extract.sv
// mmu_walk_index_extract: pulls the table index addr[bitpos-1 -: width] out of the logical address
module mmu_walk_index_extract #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [5:0]        bitpos_i,
  input  logic [3:0]        width_i,
  output logic [15:0]       idx_o
);
  logic [6:0] sh;
  // zero padding below the address lets a field that runs past bit 0 fill with zeros
  always_comb begin
    sh = 7'(bitpos_i) + 7'(ADDR_W) - 7'(width_i);
    idx_o = 16'({addr_i, {ADDR_W{1'b0}}} >> sh) & ((16'h1 << width_i) - 16'h1);
  end
endmodule

// File: rtl/mmu_table_walk_seq.sv
// mmu_table_walk_seq: short-format descriptor table walker producing a page base or a fault
module mmu_table_walk_seq
  import mmu_walk_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MAX_LEVELS = 4,
  parameter int PG_ATTR_W = PG_ATTR_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_CPU,
  input  logic              MMU_RUNTIME_REQ,
  input  logic [ADDR_W-1:0] MMU_LOG_ADDR,
  input  logic              ATC_HIT,
  input  logic [ADDR_W-1:0] ROOT_PTR,
  input  logic [4:0]        TC_IS,
  input  logic [15:0]       TC_TI,
  input  logic              BUS_BSY,
  output logic              WALK_RD_REQ,
  output logic [ADDR_W-1:0] WALK_RD_ADDR,
  input  logic              WALK_RD_ACK,
  input  logic [31:0]       WALK_RD_DATA,
  input  logic              WALK_BERR,
  output logic              MMU_RUNTIME_STALL,
  output logic              WALK_DONE,
  output logic [ADDR_W-1:0] WALK_PADDR,
  output logic              ATC_LOAD,
  output logic              WALK_FAULT,
  output logic [1:0]        WALK_FAULT_LEVEL,
  output logic              WALK_FAULT_BERR
);
  walk_state_t       state_q;
  logic [1:0]        level_q, fault_lvl_q;
  logic [5:0]        bitpos_q;
  logic [ADDR_W-1:0] addr_q, ptr_q, paddr_q;
  logic [15:0]       ti_q, idx;
  logic [31:0]       desc_q;
  logic              rd_req_q, done_q, fault_q, fault_berr_q, miss;
  logic [3:0]        ti_cur, ti_next;
  logic              unused_bus_bsy;
  assign unused_bus_bsy = BUS_BSY;
  assign miss = MMU_RUNTIME_REQ && !ATC_HIT;
  assign ti_cur = ti_field(ti_q, level_q);
  assign ti_next = ti_field(ti_q, level_q + 2'd1);
  mmu_walk_index_extract #(.ADDR_W(ADDR_W)) u_idx (
    .addr_i  (addr_q),
    .bitpos_i(bitpos_q),
    .width_i (ti_cur),
    .idx_o   (idx)
  );
  assign WALK_RD_REQ = rd_req_q;
  assign WALK_RD_ADDR = rd_req_q ? ptr_q + (ADDR_W'(idx) << 2) : '0;
  assign MMU_RUNTIME_STALL = state_q == ISSUE || state_q == DECODE || (state_q == IDLE && miss);
  assign WALK_DONE = done_q;
  assign ATC_LOAD = done_q;
  assign WALK_PADDR = paddr_q;
  assign WALK_FAULT = fault_q;
  assign WALK_FAULT_LEVEL = fault_lvl_q;
  assign WALK_FAULT_BERR = fault_berr_q;
  // walk FSM; pulse outputs are set on the transition into DONE/FAULT so they are high for that one state
  always_ff @(posedge CLK) begin
    if (RESET_CPU) begin
      state_q <= IDLE;
      level_q <= '0;
      bitpos_q <= '0;
      addr_q <= '0;
      ptr_q <= '0;
      ti_q <= '0;
      desc_q <= '0;
      paddr_q <= '0;
      rd_req_q <= 1'b0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
      fault_lvl_q <= '0;
      fault_berr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fault_q <= 1'b0;
      fault_lvl_q <= '0;
      fault_berr_q <= 1'b0;
      case (state_q)
        IDLE: if (miss) begin
          addr_q <= MMU_LOG_ADDR;
          ptr_q <= ROOT_PTR & ADDR_W'(TBL_ADDR_MASK);
          level_q <= '0;
          bitpos_q <= 6'd32 - 6'(TC_IS);
          ti_q <= TC_TI;
          if (ti_field(TC_TI, 2'd0) == 4'd0) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            state_q <= ISSUE;
            rd_req_q <= 1'b1;
          end
        end
        ISSUE: if (WALK_BERR) begin
          rd_req_q <= 1'b0;
          state_q <= FAULT;
          fault_q <= 1'b1;
          fault_berr_q <= 1'b1;
          fault_lvl_q <= level_q;
        end else if (WALK_RD_ACK) begin
          rd_req_q <= 1'b0;
          desc_q <= WALK_RD_DATA;
          bitpos_q <= bitpos_q - 6'(ti_cur);
          state_q <= DECODE;
        end
        DECODE: if (desc_q[1:0] == DT_INVALID ||
                    (desc_q[1] && (level_q == 2'(MAX_LEVELS - 1) || ti_next == 4'd0))) begin
          state_q <= FAULT;
          fault_q <= 1'b1;
          fault_lvl_q <= level_q;
        end else if (desc_q[1:0] == DT_PAGE) begin
          paddr_q <= ADDR_W'(desc_q & ~((32'h1 << PG_ATTR_W) - 32'h1));
          done_q <= 1'b1;
          state_q <= DONE;
        end else begin
          ptr_q <= ADDR_W'(desc_q & TBL_ADDR_MASK);
          level_q <= level_q + 2'd1;
          rd_req_q <= 1'b1;
          state_q <= ISSUE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
